elevator_scheduler: RTL
=======================

Name: elevator_scheduler

Overview:
Call scheduler that sequences the elevator controller FSM. It latches floor call buttons and tracks the car position with a travel timer. It chooses direction using SCAN (keep direction while calls remain ahead) and drives exactly one controller command per cycle: close_req, open_req, up_req, down_req or stop. It sits between the call-button panel and the elevator controller, and consumes the controller's status outputs.

Parameters:
NUM_FLOORS, 8, number of floors served (2..16)
FLOOR_W, 3, floor index width, equal to clog2(NUM_FLOORS)
TRAVEL_CYCLES, 16, clock cycles to travel one floor (>=2)
DOOR_CYCLES, 32, cycles the door is held open (>=2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
call_req  in  NUM_FLOORS  call button per floor; level or pulse, latched on any high cycle
ctl_open  in  1  controller open status
ctl_moving  in  1  controller moving status
ctl_error  in  1  controller error status
close_req  out  1  command to controller
open_req  out  1  command to controller
up_req  out  1  command to controller
down_req  out  1  command to controller
stop  out  1  command to controller
floor  out  FLOOR_W  current car floor
pending  out  NUM_FLOORS  latched outstanding calls
dir_up  out  1  current SCAN direction (1 = up)
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async): state IDLE, floor 0, pending 0, dir_up 1, all five commands 0, busy 0, timers 0. The car is taken to be parked at floor 0 on reset. Reset during a move discards position and all pending calls.
- All outputs are registered. From the first clock after reset deassertion, exactly one command is high every cycle.
- pending[i] sets on call_req[i]. It clears on entry to DOOR. If the set and clear for the same bit occur in the same cycle, the clear wins.
- States and commands:
  IDLE (close_req): if pending[floor], go to DOOR. Else if a call exists in dir_up's direction, go to MOVE. Else if a call exists in the opposite direction, flip dir_up and go to MOVE. Else stay.
  MOVE (up_req if dir_up, else down_req): the travel timer counts TRAVEL_CYCLES cycles. On expiry, floor changes by ±1. If pending[new floor] is set, or no calls remain ahead, go to STOP. Otherwise reload the timer and continue.
  STOP (stop, 1 cycle): go to DOOR.
  DOOR (open_req): clear pending[floor] on entry. The door timer counts DOOR_CYCLES, then go to CLOSE.
  CLOSE (close_req, 1 cycle): go to IDLE.
  FAULT (close_req, 2 cycles): go to IDLE. Keep pending and floor. Abandon any partial floor travel; floor is not updated.
- ctl_error high in any state forces FAULT on the next edge, overriding all other transitions. The error count saturates at 255 and is observable only under the optional feature.
- Floor never goes below 0 or above NUM_FLOORS-1. MOVE is entered only when a call lies strictly in the travel direction.
- Direction reverses only in IDLE, never mid-MOVE.
- A call at the car's own floor during MOVE is latched and served on a later pass.
- Status inputs are informational only. The controller's outputs lag the commands by one cycle, and the scheduler does not gate on them.

Optional Feature:
Macro: ELEV_SCHED_DOOR_REOPEN_EN
- Defined: call_req[floor] high while in DOOR reloads the door timer (hold-open); the bit is not latched. call_req[floor] in CLOSE sends the FSM back to DOOR instead of IDLE.
- Undefined: call_req[floor] during DOOR or CLOSE is ignored (not latched). The door timer never reloads.

Test Plan:
- Reset then idle, no calls: close_req=1 on every cycle; busy=0; floor=0; other commands 0 for 100 cycles.
- Idle at floor 0, pulse call_req[3]: up_req for 3×16 cycles, floor steps 1,2,3, then stop for 1 cycle, then open_req for 32 cycles, then close_req; pending[3]=0 after DOOR entry.
- At floor 3, calls 5 and 1 latched together: serves floor 5 first (dir_up=1), then flips dir_up=0 in IDLE and serves floor 1; door opens at floors 5 and 1 only.
- call_req[4] pulsed while moving up past floor 4, at the cycle floor becomes 4 (set/clear race): car stops at 4 and pending[4] ends at 0. Separately, call floor 2 while car is moving up from 2 toward 5: served after floor 5 on the down pass.
- ctl_error asserted for 1 cycle mid-MOVE: FAULT gives close_req for 2 cycles, then IDLE. pending and floor are unchanged, then travel resumes toward the same target.
- With ELEV_SCHED_DOOR_REOPEN_EN, call_req[floor] at door cycle 20: open_req continues for 32 more cycles (52 total). Without the macro: 32 total and pending[floor] stays 0.

Source files
------------

// File: rtl/elevator_scheduler.sv
// SCAN call scheduler driving one elevator-controller command per cycle.
// Optional ELEV_SCHED_DOOR_REOPEN_EN: door hold-open on own-floor call, plus error count port.
module elevator_scheduler #(
    parameter int unsigned NUM_FLOORS    = 8,
    parameter int unsigned FLOOR_W       = $clog2(NUM_FLOORS),
    parameter int unsigned TRAVEL_CYCLES = 16,
    parameter int unsigned DOOR_CYCLES   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic                  ctl_open,
    input  logic                  ctl_moving,
    input  logic                  ctl_error,
    output logic                  close_req,
    output logic                  open_req,
    output logic                  up_req,
    output logic                  down_req,
    output logic                  stop,
    output logic [FLOOR_W-1:0]    floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir_up,
`ifdef ELEV_SCHED_DOOR_REOPEN_EN
    output logic [7:0]            err_count,
`endif
    output logic                  busy
);

    localparam int unsigned TMax   = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int unsigned TimerW = $clog2(TMax);
    localparam logic [TimerW-1:0] TravelLast = TimerW'(TRAVEL_CYCLES - 1);
    localparam logic [TimerW-1:0] DoorLast   = TimerW'(DOOR_CYCLES - 1);
    localparam logic [TimerW-1:0] FaultLast  = TimerW'(1);

    typedef enum logic [2:0] {StIdle, StMove, StStop, StDoor, StClose, StFault} state_e;

    state_e                  r_state, w_state_d;
    logic                    r_dir_up, w_dir_d;
    logic [FLOOR_W-1:0]      r_floor, w_floor_d;
    logic [TimerW-1:0]       r_timer, w_timer_d;
    logic [NUM_FLOORS-1:0]   r_pending, w_pending_d;
    logic [NUM_FLOORS-1:0]   w_call_set, w_pend_eff;
    logic                    w_reopen;
    logic                    r_close, r_open, r_up, r_down, r_stop, r_busy;
    logic                    w_unused_status;

    // Status inputs are informational; the scheduler never gates on them.
    assign w_unused_status = ctl_open ^ ctl_moving;

    function automatic logic calls_ahead(input logic [NUM_FLOORS-1:0] vec,
                                         input logic [FLOOR_W-1:0]    f,
                                         input logic                  up);
        calls_ahead = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (vec[i] && ((up && i > int'(f)) || (!up && i < int'(f)))) calls_ahead = 1'b1;
        end
    endfunction

    // Own-floor calls are dropped while the door is open or closing.
    always_comb begin
        w_call_set = call_req;
        if (r_state == StDoor || r_state == StClose) w_call_set[r_floor] = 1'b0;
    end

    assign w_pend_eff = r_pending | w_call_set;

`ifdef ELEV_SCHED_DOOR_REOPEN_EN
    assign w_reopen = call_req[r_floor];
`else
    assign w_reopen = 1'b0;
`endif

    always_comb begin
        w_state_d = r_state;
        w_dir_d   = r_dir_up;
        w_floor_d = r_floor;
        w_timer_d = '0;
        unique case (r_state)
            StIdle: begin
                if (r_pending[r_floor]) begin
                    w_state_d = StDoor;
                end else if (calls_ahead(r_pending, r_floor, r_dir_up)) begin
                    w_state_d = StMove;
                end else if (calls_ahead(r_pending, r_floor, !r_dir_up)) begin
                    w_dir_d   = !r_dir_up;
                    w_state_d = StMove;
                end
            end
            StMove: begin
                if (r_timer == TravelLast) begin
                    w_floor_d = r_dir_up ? r_floor + FLOOR_W'(1) : r_floor - FLOOR_W'(1);
                    // A call arriving on the same edge as the car still stops it here.
                    if (w_pend_eff[w_floor_d] || !calls_ahead(w_pend_eff, w_floor_d, r_dir_up))
                        w_state_d = StStop;
                end else begin
                    w_timer_d = r_timer + TimerW'(1);
                end
            end
            StStop:  w_state_d = StDoor;
            StDoor: begin
                if (w_reopen) begin
                    w_timer_d = '0;
                end else if (r_timer == DoorLast) begin
                    w_state_d = StClose;
                end else begin
                    w_timer_d = r_timer + TimerW'(1);
                end
            end
            StClose: w_state_d = w_reopen ? StDoor : StIdle;
            StFault: begin
                if (r_timer == FaultLast) w_state_d = StIdle;
                else                      w_timer_d = r_timer + TimerW'(1);
            end
            default: w_state_d = StIdle;
        endcase

        if (ctl_error) begin
            w_state_d = StFault;
            w_dir_d   = r_dir_up;
            w_floor_d = r_floor;
            w_timer_d = '0;
        end

        w_pending_d = w_pend_eff;
        if (w_state_d == StDoor && r_state != StDoor) w_pending_d[w_floor_d] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StIdle;
            r_dir_up  <= 1'b1;
            r_floor   <= '0;
            r_timer   <= '0;
            r_pending <= '0;
            r_close   <= 1'b0;
            r_open    <= 1'b0;
            r_up      <= 1'b0;
            r_down    <= 1'b0;
            r_stop    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_dir_up  <= w_dir_d;
            r_floor   <= w_floor_d;
            r_timer   <= w_timer_d;
            r_pending <= w_pending_d;
            r_close   <= (w_state_d == StIdle) || (w_state_d == StClose) || (w_state_d == StFault);
            r_open    <= (w_state_d == StDoor);
            r_up      <= (w_state_d == StMove) && w_dir_d;
            r_down    <= (w_state_d == StMove) && !w_dir_d;
            r_stop    <= (w_state_d == StStop);
            r_busy    <= (w_state_d != StIdle);
        end
    end

`ifdef ELEV_SCHED_DOOR_REOPEN_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                r_err_cnt <= '0;
        else if (ctl_error && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
    end

    assign err_count = r_err_cnt;
`endif

    assign close_req = r_close;
    assign open_req  = r_open;
    assign up_req    = r_up;
    assign down_req  = r_down;
    assign stop      = r_stop;
    assign floor     = r_floor;
    assign pending   = r_pending;
    assign dir_up    = r_dir_up;
    assign busy      = r_busy;

endmodule
